// File: rtl/bcd_counter_n.sv
// Cascaded DIGITS-digit BCD up/down counter with parallel load, terminal count,
// range-limit pulse (wrap or saturate) and rejected-load pulse.
module bcd_counter_n #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  ovf,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    // Ripple a single decimal step through the digits; a digit only moves
    // when every lower digit is at its limit (9 going up, 0 going down).
    function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic up);
        logic [W-1:0] r;
        logic         carry;
        logic [3:0]   d;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (carry) begin
                if (up) begin
                    if (d == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = d + 4'd1;
                        carry       = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                    end else begin
                        r[4*i +: 4] = d - 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [W-1:0] limit_wrap(input logic up);
        return up ? '0 : ALL_NINES;
    endfunction

    logic all_nines;
    logic all_zeros;

    always_comb begin
        all_nines = (count == ALL_NINES);
        all_zeros = (count == '0);
        tc        = en & (up_dn ? all_nines : all_zeros);
    end

    // Pulses default low every cycle so each lasts exactly one clock.
    always_ff @(posedge clk) begin
        ovf      <= 1'b0;
        load_err <= 1'b0;
        if (rst) begin
            count <= '0;
        end else if (load) begin
            if (bcd_valid(load_val)) begin
                count <= load_val;
            end else begin
                load_err <= 1'b1;
            end
        end else if (en) begin
            if (tc) begin
                ovf <= 1'b1;
                if (WRAP) count <= limit_wrap(up_dn);
            end else begin
                count <= bcd_step(count, up_dn);
            end
        end
    end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench for bcd_counter_n: integer reference model, expected values
// queued by the drivers and popped by a single monitor process.
module tb_bcd_counter_n;

    typedef struct packed {
        int v;
        bit ovf;
        bit err;
    } exp_t;

    typedef struct packed {
        bit grp;
        bit ta;
        bit tb;
        bit tcc;
    } tcx_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Two-digit pair (wrap and saturate) share stimulus; three-digit instance for the sweep.
    logic        rst_ab = 1'b0, en_ab = 1'b0, up_ab = 1'b0, load_ab = 1'b0;
    logic [7:0]  lv_ab = '0;
    logic [7:0]  count_a, count_b;
    logic        tc_a, ovf_a, err_a, tc_b, ovf_b, err_b;
    logic        rst_c = 1'b0, en_c = 1'b0, up_c = 1'b0, load_c = 1'b0;
    logic [11:0] lv_c = '0;
    logic [11:0] count_c;
    logic        tc_c, ovf_c, err_c;

    bcd_counter_n #(.DIGITS(2), .WRAP(1'b1)) dut_a (
        .clk(clk), .rst(rst_ab), .en(en_ab), .up_dn(up_ab), .load(load_ab),
        .load_val(lv_ab), .count(count_a), .tc(tc_a), .ovf(ovf_a), .load_err(err_a));

    bcd_counter_n #(.DIGITS(2), .WRAP(1'b0)) dut_b (
        .clk(clk), .rst(rst_ab), .en(en_ab), .up_dn(up_ab), .load(load_ab),
        .load_val(lv_ab), .count(count_b), .tc(tc_b), .ovf(ovf_b), .load_err(err_b));

    bcd_counter_n #(.DIGITS(3), .WRAP(1'b1)) dut_c (
        .clk(clk), .rst(rst_c), .en(en_c), .up_dn(up_c), .load(load_c),
        .load_val(lv_c), .count(count_c), .tc(tc_c), .ovf(ovf_c), .load_err(err_c));

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    tcx_t qt[$];
    int   va = 0, vb = 0, vc = 0;
    int   checks = 0, errors = 0;
    int   ovf_cnt_c = 0;
    bit   done = 1'b0;

    // Reference: count held as a plain integer in 0 .. 10**nd-1.
    function automatic exp_t model(input int v, input bit r, input bit l, input bit e,
                                   input bit u, input logic [31:0] lv, input int nd,
                                   input bit wrap);
        exp_t x;
        int   lim, val, p;
        bit   ok;
        x.v = v; x.ovf = 1'b0; x.err = 1'b0;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        lim = lim - 1;
        if (r) begin
            x.v = 0;
        end else if (l) begin
            ok = 1'b1; val = 0; p = 1;
            for (int i = 0; i < nd; i++) begin
                if (lv[4*i +: 4] > 4'd9) ok = 1'b0;
                val = val + int'(lv[4*i +: 4]) * p;
                p   = p * 10;
            end
            if (ok) x.v = val;
            else    x.err = 1'b1;
        end else if (e) begin
            if (u) begin
                if (v == lim) begin x.ovf = 1'b1; x.v = wrap ? 0 : lim; end
                else x.v = v + 1;
            end else begin
                if (v == 0) begin x.ovf = 1'b1; x.v = wrap ? lim : 0; end
                else x.v = v - 1;
            end
        end
        return x;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int nd);
        logic [31:0] r;
        int          t;
        r = '0; t = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive_ab(input bit r, input bit l, input bit e, input bit u, input logic [7:0] lv);
        exp_t ea, eb;
        tcx_t t;
        @(negedge clk);
        rst_ab = r; load_ab = l; en_ab = e; up_ab = u; lv_ab = lv;
        t.grp = 1'b0;
        t.ta  = e && (u ? (va == 99) : (va == 0));
        t.tb  = e && (u ? (vb == 99) : (vb == 0));
        t.tcc = 1'b0;
        qt.push_back(t);
        ea = model(va, r, l, e, u, {24'd0, lv}, 2, 1'b1);
        eb = model(vb, r, l, e, u, {24'd0, lv}, 2, 1'b0);
        qa.push_back(ea);
        qb.push_back(eb);
        va = ea.v;
        vb = eb.v;
    endtask

    task automatic drive_c(input bit r, input bit l, input bit e, input bit u, input logic [11:0] lv);
        exp_t ec;
        tcx_t t;
        @(negedge clk);
        rst_c = r; load_c = l; en_c = e; up_c = u; lv_c = lv;
        t.grp = 1'b1; t.ta = 1'b0; t.tb = 1'b0;
        t.tcc = e && (u ? (vc == 999) : (vc == 0));
        qt.push_back(t);
        ec = model(vc, r, l, e, u, {20'd0, lv}, 3, 1'b1);
        qc.push_back(ec);
        vc = ec.v;
    endtask

    // Monitor: tc checked mid-cycle, registered outputs just after each rising edge.
    always begin : mon
        tcx_t        t;
        exp_t        e;
        logic [31:0] x;
        @(negedge clk);
        #2;
        while (qt.size() != 0) begin
            t = qt.pop_front();
            if (t.grp == 1'b0) begin
                chk("tc_a", {31'd0, tc_a}, {31'd0, t.ta});
                chk("tc_b", {31'd0, tc_b}, {31'd0, t.tb});
            end else begin
                chk("tc_c", {31'd0, tc_c}, {31'd0, t.tcc});
            end
        end
        if (done) begin
            chk("queues_drained", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
            chk("sweep_ovf_count", 32'(ovf_cnt_c), 32'd1);
            chk("sweep_final_count", {20'd0, count_c}, 32'd0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
        @(posedge clk);
        #1;
        if (qa.size() != 0) begin
            e = qa.pop_front();
            x = to_bcd(e.v, 2);
            chk("count_a", {24'd0, count_a}, x);
            chk("ovf_a", {31'd0, ovf_a}, {31'd0, e.ovf});
            chk("load_err_a", {31'd0, err_a}, {31'd0, e.err});
        end
        if (qb.size() != 0) begin
            e = qb.pop_front();
            x = to_bcd(e.v, 2);
            chk("count_b", {24'd0, count_b}, x);
            chk("ovf_b", {31'd0, ovf_b}, {31'd0, e.ovf});
            chk("load_err_b", {31'd0, err_b}, {31'd0, e.err});
        end
        if (qc.size() != 0) begin
            e = qc.pop_front();
            x = to_bcd(e.v, 3);
            chk("count_c", {20'd0, count_c}, x);
            chk("ovf_c", {31'd0, ovf_c}, {31'd0, e.ovf});
            chk("load_err_c", {31'd0, err_c}, {31'd0, e.err});
            if (ovf_c === 1'b1) ovf_cnt_c++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] lv;
        // Reset state
        drive_ab(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        drive_ab(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        // Up rollover from 98
        drive_ab(1'b0, 1'b1, 1'b0, 1'b1, 8'h98);
        repeat (3) drive_ab(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        drive_ab(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        // Down to zero and beyond
        drive_ab(1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
        repeat (3) drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        // Inter-digit carry and borrow
        drive_ab(1'b0, 1'b1, 1'b0, 1'b1, 8'h09);
        drive_ab(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        drive_ab(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        // Rejected load, then accepted load with enable high
        drive_ab(1'b0, 1'b1, 1'b1, 1'b1, 8'h3A);
        drive_ab(1'b0, 1'b1, 1'b1, 1'b1, 8'h37);
        drive_ab(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        // Reset beats load and a terminal step
        drive_ab(1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
        drive_ab(1'b1, 1'b1, 1'b1, 1'b1, 8'h99);
        drive_ab(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        // Randomised traffic, loads biased toward the range limits
        for (int n = 0; n < 400; n++) begin
            lv = 8'($urandom);
            if ($urandom_range(0, 3) == 0) lv = ($urandom_range(0, 1) == 1) ? 8'h98 : 8'h01;
            drive_ab(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 3) != 0), 1'($urandom), lv);
        end
        drive_ab(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        // Full three-digit sweep
        drive_c(1'b1, 1'b0, 1'b0, 1'b1, 12'h000);
        repeat (1000) drive_c(1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        drive_c(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        repeat (3) @(negedge clk);
        done = 1'b1;
    end

endmodule

// File: doc/bcd_counter_n.md
BCD_COUNTER_N -- requirements
Module: bcd_counter_n

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of cascaded decimal digits (legal range 1..8).
REQ-002 SHALL have parameter WRAP, default 1: 1 = roll over at the range limit, 0 = saturate at the range limit.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port en, input, 1 bit: count enable.
REQ-006 SHALL have port up_dn, input, 1 bit: direction; 1 = up, 0 = down.
REQ-007 SHALL have port load, input, 1 bit: parallel load strobe.
REQ-008 SHALL have port load_val, input, 4*DIGITS bits: BCD load value; digit i occupies bits [4i+3:4i], digit 0 least significant.
REQ-009 SHALL have port count, output, 4*DIGITS bits: registered BCD count, with the same digit packing as load_val.
REQ-010 SHALL have port tc, output, 1 bit: combinational terminal-count indication.
REQ-011 SHALL have port ovf, output, 1 bit: registered one-cycle pulse on a range-limit event.
REQ-012 SHALL have port load_err, output, 1 bit: registered one-cycle pulse on a rejected load.

Function
REQ-013 SHALL apply priority per clock edge as follows: rst, then load, then en, then hold.
REQ-014 SHALL, on load with every load_val digit <= 9, set count = load_val on the next edge, regardless of en or up_dn.
REQ-015 SHALL, on load with any load_val digit > 9, leave count unchanged, pulse load_err high for exactly one cycle, and perform no counting that cycle.
REQ-016 SHALL hold count when en = 0 and load = 0.
REQ-017 SHALL, counting up, increment digit i only when en = 1 and all digits below i equal 9; a digit at 9 so stepped becomes 0.
REQ-018 SHALL, counting down, decrement digit i only when en = 1 and all digits below i equal 0; a digit at 0 so stepped becomes 9.
REQ-019 SHALL advance count by exactly 1 (decimal) per enabled cycle, with 1-cycle latency from en to count.
REQ-020 SHALL drive tc = en & (up_dn ? all digits == 9 : all digits == 0), with no register in the path.
REQ-021 SHALL, on an enabled step with tc = 1 and load = 0, produce one of two results depending on WRAP:
- WRAP = 1: count goes to all 0 (up) or all 9 (down).
- WRAP = 0: count holds.
REQ-022 SHALL raise ovf for exactly one cycle, in the cycle after each step described in REQ-021, for both WRAP settings.
REQ-023 SHALL take the direction for each cycle from up_dn sampled at that edge; changing direction mid-count requires no idle cycle.
REQ-024 SHALL never let any digit of count hold a value > 9.
REQ-025 SHALL clear ovf and load_err in any cycle where their trigger condition is absent.

Reset
REQ-026 SHALL, when rst = 1 at a clock edge, set count = 0, ovf = 0 and load_err = 0, overriding load and en.
REQ-027 SHALL, if rst is asserted mid-count or coincident with a terminal step, suppress that cycle's ovf.
REQ-028 SHALL, on the first edge after rst deasserts, act on that edge's inputs normally.

Verification (DIGITS = 2 unless stated)
REQ-029 SHALL cover up-count rollover: WRAP=1, load 98, en=1, up=1 for 3 cycles -> count 99, 00, 01; tc=1 while count is 99; ovf high only in the cycle count shows 00.
REQ-030 SHALL cover down-count saturation: WRAP=0, load 01, en=1, up=0 for 3 cycles -> count 00, 00, 00; ovf pulses once for each enabled step taken at 00.
REQ-031 SHALL cover inter-digit carry: load 09, one up step -> 10; then one down step -> 09; digit 1 changes only on those edges.
REQ-032 SHALL cover a rejected load: load_val = 0x3A -> count unchanged, load_err high for one cycle; load 0x37 with en=1 in the same cycle -> count 37, no increment.
REQ-033 SHALL cover reset priority: with count 99, assert rst with load=1, en=1, up=1 -> count 00, ovf 0, load_err 0.
REQ-034 SHALL cover a full-range sweep: DIGITS=3, WRAP=1, reset, then 1000 up steps -> count returns to 000 with exactly one ovf; a reference model is compared every cycle.
